// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared default geometry for the synchronous FIFO
package sync_fifo_pkg;
    localparam int D_SIZE_DEF = 8;
    localparam int A_SIZE_DEF = 4;
endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake and status bundle for sync_fifo
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF
);
    logic              wen;
    logic [D_SIZE-1:0] wdata;
    logic              ren;
    logic [D_SIZE-1:0] rdata;
    logic              empty;
    logic              full;
    modport master (output wen, wdata, ren, input rdata, empty, full);
    modport slave  (input wen, wdata, ren, output rdata, empty, full);
endinterface

// File: rtl/sync_fifo_mem.sv
// fifo_mem: DEPTH x D_SIZE storage, synchronous write, asynchronous read
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF,
    parameter int A_SIZE = A_SIZE_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [A_SIZE-1:0] waddr,
    input  logic [D_SIZE-1:0] wdata,
    input  logic [A_SIZE-1:0] raddr,
    output logic [D_SIZE-1:0] rdata
);
    logic [D_SIZE-1:0] mem [2**A_SIZE];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and a registered read port
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF,
    parameter int A_SIZE = A_SIZE_DEF
) (
    input logic        clk,
    input logic        rst,
    sync_fifo_if.slave bus
);
    logic [A_SIZE:0]   wptr, rptr;
    logic [D_SIZE-1:0] rdata_q, mem_rdata;
    logic              empty, full, do_w, do_r;
    always_comb begin
        empty = wptr == rptr;
        full  = wptr[A_SIZE-1:0] == rptr[A_SIZE-1:0] && wptr[A_SIZE] != rptr[A_SIZE];
        do_w  = bus.wen && !full;
        do_r  = bus.ren && !empty;
    end
    // reset cycle must not leave a stray word in memory either
    fifo_mem #(.D_SIZE(D_SIZE), .A_SIZE(A_SIZE)) u_mem (
        .clk  (clk),
        .we   (do_w && !rst),
        .waddr(wptr[A_SIZE-1:0]),
        .wdata(bus.wdata),
        .raddr(rptr[A_SIZE-1:0]),
        .rdata(mem_rdata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            rdata_q <= '0;
        end else begin
            if (do_w) wptr <= wptr + (A_SIZE+1)'(1);
            if (do_r) begin
                rptr    <= rptr + (A_SIZE+1)'(1);
                rdata_q <= mem_rdata;
            end
        end
    end
    assign bus.rdata = rdata_q;
    assign bus.empty = empty;
    assign bus.full  = full;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed stimulus with a queue scoreboard and an independent read monitor
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] q[$];

    sync_fifo_if #(.D_SIZE(8)) bus ();
    sync_fifo #(.D_SIZE(8), .A_SIZE(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // the queue depth is the bench's occupancy model: a read is due whenever it holds data
    always @(posedge clk) begin
        if (!rst && bus.ren && q.size() != 0) begin
            logic [7:0] e;
            e = q.pop_front();
            #1 chk("rdata", {24'h0, bus.rdata}, {24'h0, e});
        end
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic push);
        @(negedge clk);
        bus.wen = w;
        bus.wdata = d;
        bus.ren = r;
        @(posedge clk);
        #2;
        if (push) q.push_back(d);
        chk("empty", bus.empty, q.size() == 0);
        chk("full", bus.full, q.size() == 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wen = 0;
        bus.ren = 0;
        bus.wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_rdata", bus.rdata, 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 8'(i), 0, 1);
            chk("fill_full", bus.full, i == 16);
        end
        cyc(1, 8'hAA, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
        chk("drain_empty", bus.empty, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            chk("hold_rdata", bus.rdata, 8'h10);
        end
        cyc(1, 8'h55, 0, 1);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 8'h20 + 8'(i), 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(1, 8'h30 + 8'(i), 0, 1);
        chk("wrap_full14", bus.full, 0);
        cyc(1, 8'h3C, 0, 1);
        cyc(1, 8'h3D, 0, 1);
        chk("wrap_full16", bus.full, 1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'h40 + 8'(i), 0, 1);
        for (int i = 0; i < 20; i++) cyc(1, 8'h45 + 8'(i), 1, 1);
        for (int i = 0; i < 11; i++) cyc(1, 8'h60 + 8'(i), 0, 1);
        chk("both_pre_full", bus.full, 1);
        cyc(1, 8'hEE, 1, 0);
        chk("both_full_after", bus.full, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);
        cyc(1, 8'h77, 1, 1);
        chk("both_empty_after", bus.empty, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'h80 + 8'(i), 0, 1);
        @(negedge clk);
        rst = 1;
        bus.wen = 1;
        bus.ren = 1;
        bus.wdata = 8'hBB;
        @(posedge clk);
        #2 q.delete();
        @(negedge clk);
        rst = 0;
        bus.wen = 0;
        bus.ren = 0;
        chk("mid_rst_empty", bus.empty, 1);
        chk("mid_rst_full", bus.full, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        cyc(1, 8'h99, 0, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter D_SIZE, default 8, data word width in bits.
REQ-002 Parameter A_SIZE, default 4, address width; depth DEPTH = 2**A_SIZE (16 by default).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 wen  input  1  write request.
REQ-006 wdata  input  D_SIZE  write data.
REQ-007 ren  input  1  read request.
REQ-008 rdata  output  D_SIZE  read data, registered.
REQ-009 empty  output  1  high when FIFO holds 0 words.
REQ-010 full  output  1  high when FIFO holds DEPTH words.

Function
REQ-011 Write accepted at a rising edge iff wen=1 and full=0; wdata is stored at the write pointer and the write pointer increments.
REQ-012 Read accepted at a rising edge iff ren=1 and empty=0; the word at the read pointer is loaded into rdata at that same edge and the read pointer increments.
REQ-013 Read latency: rdata shows the popped word from the edge that accepts the read until the next accepted read; rdata holds its value otherwise.
REQ-014 Write with full=1 is dropped: no storage change, no pointer change, no error flag.
REQ-015 Read with empty=1 is ignored: rdata and pointers are unchanged.
REQ-016 Pointers are A_SIZE+1 bits binary; the low A_SIZE bits address memory; the MSB is the wrap bit.
REQ-017 empty = (wptr == rptr); full = (low bits equal) and (MSBs differ); both flags are combinational from registered pointers.
REQ-018 Pointers wrap from DEPTH-1 to 0 with MSB toggle; ordering is strict FIFO across wrap.
REQ-019 Simultaneous wen and ren with neither flag set: both are performed in the same edge, and occupancy is unchanged.
REQ-020 Simultaneous wen and ren while full: the read is performed, the write is dropped, and full deasserts the next cycle.
REQ-021 Simultaneous wen and ren while empty: the write is performed, the read is ignored (no fall-through), and empty deasserts the next cycle.
REQ-022 Flag gating uses flag values before the edge only.

Reset
REQ-023 While rst=1 at a rising edge: wptr=0, rptr=0, rdata=0, so empty=1 and full=0 from the following cycle.
REQ-024 Reset mid-operation discards all contents and ignores wen/ren in that cycle.
REQ-025 Memory array is not reset; contents are unobservable until written.

Structure
REQ-026 Shared package sync_fifo_pkg holds default D_SIZE/A_SIZE constants.
REQ-027 One sub-module fifo_mem: DEPTH x D_SIZE array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr); the rdata register stays in sync_fifo.

Verification
REQ-028 Hold rst=1 for 2 clks, release -> empty=1, full=0, rdata=0.
REQ-029 Write 0x01..0x10 (16 words) -> full=1 after the 16th edge; read 16 -> rdata 0x01..0x10 in order, each value on its accepting edge, and empty=1 after the last read.
REQ-030 When full, write 0xAA -> dropped; the subsequent 16 reads never return 0xAA.
REQ-031 When empty, ren=1 for 3 clks -> rdata holds its last value, pointers are unchanged, and empty stays 1.
REQ-032 Fill 10 words, read 8, then write 12 (wraps) -> reads return all 14 words in order, and full asserts exactly at occupancy 16.
REQ-033 At occupancy 5, wen=ren=1 for 20 clks with an incrementing pattern -> empty/full are never asserted and output order is preserved; then full+both -> read done, write dropped; empty+both -> write done, empty=0 next cycle.
